// File: rtl/gpio_pad_ctrl.sv
// GPIO pad bank controller: registered pad drive/enable/pull, two-flop input
// synchroniser, per-pin debounce and edge-triggered interrupt pending bits.
module gpio_pad_ctrl #(
  parameter int NUM_PINS = 32,
  parameter int DB_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_PINS-1:0] dir_i,
  input  logic [NUM_PINS-1:0] out_i,
  input  logic [NUM_PINS-1:0] pull_en_i,
  input  logic [NUM_PINS-1:0] db_en_i,
  input  logic [DB_WIDTH-1:0] db_thresh_i,
  input  logic [NUM_PINS-1:0] int_en_i,
  input  logic [NUM_PINS-1:0] int_type_i,
  input  logic [NUM_PINS-1:0] int_clr_i,
  output logic [NUM_PINS-1:0] data_o,
  output logic [NUM_PINS-1:0] int_pend_o,
  output logic                irq_o,
  output logic [NUM_PINS-1:0] pad_i_o,
  output logic [NUM_PINS-1:0] pad_oen_o,
  output logic [NUM_PINS-1:0] pad_ren_o,
  input  logic [NUM_PINS-1:0] pad_c_i
);

  localparam logic [DB_WIDTH-1:0] CNT_ONE = DB_WIDTH'(1);

  logic [NUM_PINS-1:0] pad_i_q, pad_oen_q, pad_ren_q;
  logic [NUM_PINS-1:0] s1_q, s2_q;
  logic [NUM_PINS-1:0] stable_q, stable_d;
  logic [NUM_PINS-1:0] pend_q, pend_d;
  logic [NUM_PINS-1:0] rise, fall;
  logic                irq_q;
  logic [DB_WIDTH-1:0] cnt_q [NUM_PINS];
  logic [DB_WIDTH-1:0] cnt_d [NUM_PINS];

  // The counter only advances while the synchronised level disagrees with the
  // stable value; the >= compare lets a lowered threshold release immediately.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_PINS; i++) begin
      cnt_d[i] = '0;
      if (!db_en_i[i]) begin
        stable_d[i] = s2_q[i];
      end else if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] >= db_thresh_i) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    rise   = stable_d & ~stable_q;
    fall   = ~stable_d & stable_q;
    pend_d = (pend_q & ~int_clr_i)
           | (int_en_i & ((int_type_i & fall) | (~int_type_i & rise)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_i_q   <= '0;
      pad_oen_q <= '1;
      pad_ren_q <= '1;
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      pend_q    <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= '0;
    end else begin
      pad_i_q   <= out_i;
      pad_oen_q <= ~dir_i;
      pad_ren_q <= ~pull_en_i;
      s1_q      <= pad_c_i;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      pend_q    <= pend_d;
      irq_q     <= |pend_d;
      for (int i = 0; i < NUM_PINS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign data_o     = stable_q;
  assign int_pend_o = pend_q;
  assign irq_o      = irq_q;
  assign pad_i_o    = pad_i_q;
  assign pad_oen_o  = pad_oen_q;
  assign pad_ren_o  = pad_ren_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl: pad drive path, sync/debounce latency,
// glitch rejection, interrupt set/clear priority and mid-operation reset.
module tb_gpio_pad_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] dir_i, out_i, pull_en_i, db_en_i, int_en_i, int_type_i, int_clr_i, pad_c_i;
  logic [15:0] db_thresh_i;
  logic [31:0] data_o, int_pend_o, pad_i_o, pad_oen_o, pad_ren_o;
  logic        irq_o;

  int n_chk  = 0;
  int n_pass = 0;

  gpio_pad_ctrl #(.NUM_PINS(32), .DB_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dir_i(dir_i), .out_i(out_i), .pull_en_i(pull_en_i),
    .db_en_i(db_en_i), .db_thresh_i(db_thresh_i), .int_en_i(int_en_i),
    .int_type_i(int_type_i), .int_clr_i(int_clr_i), .data_o(data_o),
    .int_pend_o(int_pend_o), .irq_o(irq_o), .pad_i_o(pad_i_o), .pad_oen_o(pad_oen_o),
    .pad_ren_o(pad_ren_o), .pad_c_i(pad_c_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_i = 1'b1; dir_i = '0; out_i = '0; pull_en_i = '0; db_en_i = '0;
    int_en_i = '0; int_type_i = '0; int_clr_i = '0; pad_c_i = '0; db_thresh_i = '0;

    // reset
    tick(2);
    chk("rst_oen",  pad_oen_o,  32'hFFFF_FFFF);
    chk("rst_padi", pad_i_o,    32'h0);
    chk("rst_ren",  pad_ren_o,  32'hFFFF_FFFF);
    chk("rst_data", data_o,     32'h0);
    chk("rst_pend", int_pend_o, 32'h0);
    chk("rst_irq",  {31'd0, irq_o}, 32'h0);
    rst_i = 1'b0;

    // output path and read-back on pin 0, pull on pin 1
    dir_i[0] = 1'b1; out_i[0] = 1'b1; pull_en_i[1] = 1'b1;
    tick();
    chk("out_oen",  pad_oen_o,  32'hFFFF_FFFE);
    chk("out_padi", pad_i_o,    32'h0000_0001);
    chk("out_ren",  pad_ren_o,  32'hFFFF_FFFD);
    pad_c_i[0] = 1'b1;
    tick(2);
    chk("rb_early", data_o, 32'h0);
    tick();
    chk("rb_data",  data_o, 32'h0000_0001);

    // debounce on pin 3, T=4: 4-cycle glitch rejected, then 7-cycle latency
    db_en_i[3] = 1'b1; db_thresh_i = 16'd4;
    pad_c_i[3] = 1'b1;
    tick(4);
    pad_c_i[3] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("glitch", {31'd0, data_o[3]}, 32'h0);
    end
    pad_c_i[3] = 1'b1;
    tick(6);
    chk("db_lat6", {31'd0, data_o[3]}, 32'h0);
    tick();
    chk("db_lat7", {31'd0, data_o[3]}, 32'h1);

    // falling-edge interrupt on pin 5 (bypass)
    int_en_i[5] = 1'b1; int_type_i[5] = 1'b1;
    pad_c_i[5] = 1'b1;
    tick(3);
    chk("p5_hi",      {31'd0, data_o[5]}, 32'h1);
    chk("p5_norise",  int_pend_o, 32'h0);
    pad_c_i[5] = 1'b0;
    tick(2);
    chk("p5_prefall", int_pend_o, 32'h0);
    tick();
    chk("p5_lo",      {31'd0, data_o[5]}, 32'h0);
    chk("p5_pend",    int_pend_o, 32'h0000_0020);
    chk("p5_irq",     {31'd0, irq_o}, 32'h1);
    int_en_i[5] = 1'b0;
    tick();
    chk("p5_en_off",  int_pend_o, 32'h0000_0020);
    int_clr_i[5] = 1'b1;
    tick();
    int_clr_i[5] = 1'b0;
    chk("p5_clr",     int_pend_o, 32'h0);
    chk("p5_clr_irq", {31'd0, irq_o}, 32'h0);

    // rising edge coinciding with clear: set wins
    int_en_i[5] = 1'b1; int_type_i[5] = 1'b0;
    pad_c_i[5] = 1'b1;
    tick(2);
    int_clr_i[5] = 1'b1;
    tick();
    int_clr_i[5] = 1'b0;
    chk("setwins",     int_pend_o, 32'h0000_0020);
    chk("setwins_irq", {31'd0, irq_o}, 32'h1);
    int_clr_i[5] = 1'b1;
    tick();
    int_clr_i[5] = 1'b0;
    chk("clr2", int_pend_o, 32'h0);

    // rising edge with falling type selected: no pending
    int_en_i[5] = 1'b0;
    pad_c_i[5] = 1'b0;
    tick(4);
    int_en_i[5] = 1'b1; int_type_i[5] = 1'b1;
    pad_c_i[5] = 1'b1;
    tick(4);
    chk("rise_type1", int_pend_o, 32'h0);
    int_en_i[5] = 1'b0;

    // threshold lowered mid-count on pin 7
    db_en_i[7] = 1'b1; db_thresh_i = 16'd10;
    pad_c_i[7] = 1'b1;
    tick(9);
    chk("t10_cnt7", {31'd0, data_o[7]}, 32'h0);
    db_thresh_i = 16'd3;
    tick();
    chk("t_lower", {31'd0, data_o[7]}, 32'h1);

    // reset mid-count on pin 8, interrupt armed on rising edge
    db_thresh_i = 16'd10; db_en_i[8] = 1'b1;
    int_en_i[8] = 1'b1; int_type_i[8] = 1'b0;
    pad_c_i[8] = 1'b1;
    tick(6);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("mid_rst_data", data_o, 32'h0);
    chk("mid_rst_pend", int_pend_o, 32'h0);
    chk("mid_rst_irq",  {31'd0, irq_o}, 32'h0);
    chk("mid_rst_oen",  pad_oen_o, 32'hFFFF_FFFF);
    tick(12);
    chk("p8_restart",  {31'd0, data_o[8]}, 32'h0);
    tick();
    chk("p8_data",     {31'd0, data_o[8]}, 32'h1);
    chk("p8_pend",     int_pend_o, 32'h0000_0100);
    chk("p8_irq",      {31'd0, irq_o}, 32'h1);
    chk("p0_readback", {31'd0, data_o[0]}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
